mlaccel_qpi_slave: RTL and testbench

//  Device-side QPI link layer for mlaccel_top: responder to the host QPI master.

---
 rtl/mlaccel_qpi_pkg.sv | 23 ++
 rtl/mlaccel_qpi_sync.sv | 59 +++++
 rtl/mlaccel_qpi_slave.sv | 161 ++++++++++++++++
 tb/tb_mlaccel_qpi_slave.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_qpi_pkg.sv
// Shared definitions for the mlaccel QPI device-side link layer:
// FSM state encoding, fill byte default and the command opcodes seen upstream.
package mlaccel_qpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_HI     = 3'd1,
    ST_RX_LO     = 3'd2,
    ST_TURN_FALL = 3'd3,
    ST_TURN_RISE = 3'd4,
    ST_TX_HI     = 3'd5,
    ST_TX_LO     = 3'd6
  } qpi_state_t;

  localparam logic [7:0] QPI_TX_FILL_DEFAULT  = 8'hFF;
  localparam int         QPI_SYNC_LEN_DEFAULT = 2;

  localparam logic [7:0] QPI_CMD_WRITE  = 8'h21;
  localparam logic [7:0] QPI_CMD_READ   = 8'h22;
  localparam logic [7:0] QPI_CMD_POLL   = 8'h23;
  localparam logic [7:0] QPI_CMD_STATUS = 8'h24;

endpackage

// File: rtl/mlaccel_qpi_sync.sv
// Pad synchroniser for csb/clk/io plus registered edge detection; the data nibble
// is taken from the same stage the clk edge is detected on so both stay aligned.
module mlaccel_qpi_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic       csb_s,
  output logic       csb_rise,
  output logic       csb_fall,
  output logic       clk_fall,
  output logic       clk_rise,
  output logic [3:0] io_s
);

  // Idle bus: csb and clk high, so reset never produces a spurious edge.
  localparam logic [5:0] PADS_IDLE = 6'b11_0000;

  logic [5:0] stage_r [SYNC_LEN];
  logic [1:0] prev_r;
  logic [5:0] last_s;

  assign last_s = stage_r[SYNC_LEN-1];

  // Synchroniser chain and the extra flop used for edge comparison
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_LEN; i++) stage_r[i] <= PADS_IDLE;
      prev_r <= PADS_IDLE[5:4];
    end else begin
      stage_r[0] <= {qpi_csb, qpi_clk, qpi_io_di};
      for (int i = 1; i < SYNC_LEN; i++) stage_r[i] <= stage_r[i-1];
      prev_r <= last_s[5:4];
    end
  end

  // Registered edge strobes and the matching data nibble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csb_s    <= 1'b1;
      csb_rise <= 1'b0;
      csb_fall <= 1'b0;
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      io_s     <= 4'h0;
    end else begin
      csb_s    <= last_s[5];
      csb_rise <= last_s[5] & ~prev_r[1];
      csb_fall <= ~last_s[5] & prev_r[1];
      clk_rise <= last_s[4] & ~prev_r[0];
      clk_fall <= ~last_s[4] & prev_r[0];
      io_s     <= last_s[3:0];
    end
  end

endmodule

// File: rtl/mlaccel_qpi_slave.sv
// QPI responder: deserialises host nibble pairs into bytes, turns the bus around on
// request and serialises response bytes, with tristate control and error flagging.
module mlaccel_qpi_slave
  import mlaccel_qpi_pkg::*;
#(
  parameter logic [7:0] TX_FILL  = QPI_TX_FILL_DEFAULT,
  parameter int         SYNC_LEN = QPI_SYNC_LEN_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic [3:0] qpi_io_do,
  output logic       qpi_io_oe,
  output logic       qpi_rdy,
  output logic       qpi_err,
  input  logic       core_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  qpi_state_t state_r, state_s;
  logic       csb_s, csb_rise, csb_fall, clk_fall, clk_rise;
  logic [3:0] io_s;
  logic       fall_s, rise_s;
  logic [7:0] tx_byte_s;
  logic [3:0] hi_nib_r, hi_nib_s, tx_lo_r, tx_lo_s, do_s;
  logic       first_r, first_s, oe_s, err_s, rdy_s;
  logic [7:0] rx_data_s;
  logic       rx_valid_s, rx_first_s, tx_ready_s;

  mlaccel_qpi_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .qpi_csb   (qpi_csb),
    .qpi_clk   (qpi_clk),
    .qpi_io_di (qpi_io_di),
    .csb_s     (csb_s),
    .csb_rise  (csb_rise),
    .csb_fall  (csb_fall),
    .clk_fall  (clk_fall),
    .clk_rise  (clk_rise),
    .io_s      (io_s)
  );

  // Clock edges only count while the host holds the device selected.
  assign fall_s    = clk_fall & ~csb_s;
  assign rise_s    = clk_rise & ~csb_s;
  assign tx_byte_s = tx_valid ? tx_data : TX_FILL;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; a CSB release overrides any edge or request in the same cycle
  always_comb begin
    state_s = state_r;
    if (csb_rise) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:      state_s = csb_fall ? ST_RX_HI : ST_IDLE;
        ST_RX_HI:     state_s = tx_start ? ST_TURN_FALL : (fall_s ? ST_RX_LO : ST_RX_HI);
        ST_RX_LO:     state_s = rise_s ? ST_RX_HI : ST_RX_LO;
        ST_TURN_FALL: state_s = fall_s ? ST_TURN_RISE : ST_TURN_FALL;
        ST_TURN_RISE: state_s = rise_s ? ST_TX_HI : ST_TURN_RISE;
        ST_TX_HI:     state_s = fall_s ? ST_TX_LO : ST_TX_HI;
        ST_TX_LO:     state_s = rise_s ? ST_TX_HI : ST_TX_LO;
        default:      state_s = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    do_s       = qpi_io_do;
    oe_s       = qpi_io_oe;
    rx_data_s  = rx_data;
    rx_valid_s = 1'b0;
    rx_first_s = 1'b0;
    tx_ready_s = 1'b0;
    hi_nib_s   = hi_nib_r;
    tx_lo_s    = tx_lo_r;
    first_s    = first_r;
    err_s      = qpi_err;
    rdy_s      = ~core_busy & (state_r == ST_IDLE);
    if (csb_rise) begin
      oe_s  = 1'b0;
      err_s = qpi_err | (state_r == ST_RX_LO);
    end else begin
      if (tx_start && (state_r != ST_RX_HI)) err_s = 1'b1;
      else if ((state_r == ST_IDLE) && csb_fall) err_s = 1'b0;
      else err_s = qpi_err;
      case (state_r)
        ST_IDLE:  first_s  = csb_fall ? 1'b1 : first_r;
        ST_RX_HI: hi_nib_s = (fall_s && !tx_start) ? io_s : hi_nib_r;
        ST_RX_LO: begin
          if (rise_s) begin
            rx_data_s  = {hi_nib_r, io_s};
            rx_valid_s = 1'b1;
            rx_first_s = first_r;
            first_s    = 1'b0;
          end else begin
            rx_valid_s = 1'b0;
          end
        end
        ST_TURN_RISE, ST_TX_LO: begin
          // High nibble is driven right after the rise, a half-period before the host samples it.
          if (rise_s) begin
            oe_s       = 1'b1;
            do_s       = tx_byte_s[7:4];
            tx_lo_s    = tx_byte_s[3:0];
            tx_ready_s = tx_valid;
          end else begin
            tx_ready_s = 1'b0;
          end
        end
        ST_TX_HI: do_s = fall_s ? tx_lo_r : qpi_io_do;
        default:  oe_s = qpi_io_oe;
      endcase
    end
  end

  // Output and datapath registers; reset releases the bus immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qpi_io_do <= 4'h0;
      qpi_io_oe <= 1'b0;
      qpi_rdy   <= 1'b0;
      qpi_err   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_ready  <= 1'b0;
      hi_nib_r  <= 4'h0;
      tx_lo_r   <= 4'h0;
      first_r   <= 1'b0;
    end else begin
      qpi_io_do <= do_s;
      qpi_io_oe <= oe_s;
      qpi_rdy   <= rdy_s;
      qpi_err   <= err_s;
      rx_data   <= rx_data_s;
      rx_valid  <= rx_valid_s;
      rx_first  <= rx_first_s;
      tx_ready  <= tx_ready_s;
      hi_nib_r  <= hi_nib_s;
      tx_lo_r   <= tx_lo_s;
      first_r   <= first_s;
    end
  end

endmodule

// File: tb/tb_mlaccel_qpi_slave.sv
// Self-checking bench for mlaccel_qpi_slave: a host QPI master driving the pads and a
// simple core model, compared against byte-level expectations.
module tb_mlaccel_qpi_slave;

  localparam int H = 8;  // core cycles per host half-period

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       host_csb = 1'b1;
  logic       host_clk = 1'b1;
  logic [3:0] host_io = 4'h0;
  logic [3:0] qpi_io_di;
  logic [3:0] qpi_io_do;
  logic       qpi_io_oe, qpi_rdy, qpi_err;
  logic       core_busy = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic       rxf_q[$];
  int         tx_ready_cnt = 0;

  logic [7:0] slot_data[16];
  logic       slot_valid[16];
  logic [7:0] got[16];
  logic       oe_at_dummy;

  assign qpi_io_di = qpi_io_oe ? qpi_io_do : host_io;

  mlaccel_qpi_slave dut (
    .clock     (clock),
    .reset     (reset),
    .qpi_csb   (host_csb),
    .qpi_clk   (host_clk),
    .qpi_io_di (qpi_io_di),
    .qpi_io_do (qpi_io_do),
    .qpi_io_oe (qpi_io_oe),
    .qpi_rdy   (qpi_rdy),
    .qpi_err   (qpi_err),
    .core_busy (core_busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clock = ~clock;

  // Core-side monitor: collects received bytes and counts consumed response bytes
  always @(negedge clock) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rxf_q.push_back(rx_first);
    end
    if (tx_ready) tx_ready_cnt = tx_ready_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic host_begin();
    host_csb = 1'b0;
    wait_cyc(H);
  endtask

  task automatic host_end();
    host_csb = 1'b1;
    host_clk = 1'b1;
    wait_cyc(H);
  endtask

  task automatic host_send(input logic [7:0] b);
    host_io  = b[7:4];
    host_clk = 1'b0;
    wait_cyc(H);
    host_io  = b[3:0];
    host_clk = 1'b1;
    wait_cyc(H);
  endtask

  task automatic core_tx_start();
    tx_start = 1'b1;
    wait_cyc(1);
    tx_start = 1'b0;
  endtask

  // Host read phase: dummy clock, then n bytes; the last rise coincides with CSB release.
  task automatic host_read(input int n);
    logic [3:0] hi;
    host_clk = 1'b0;
    wait_cyc(H);
    oe_at_dummy = qpi_io_oe;
    tx_valid = slot_valid[0];
    tx_data  = slot_data[0];
    host_clk = 1'b1;
    wait_cyc(H);
    for (int i = 0; i < n; i++) begin
      hi = qpi_io_do;
      host_clk = 1'b0;
      wait_cyc(H);
      got[i] = {hi, qpi_io_do};
      if (i == n - 1) begin
        tx_valid = 1'b0;
        host_csb = 1'b1;
        host_clk = 1'b1;
      end else begin
        tx_valid = slot_valid[i+1];
        tx_data  = slot_data[i+1];
        host_clk = 1'b1;
      end
      wait_cyc(H);
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(3);
    checks++; if (qpi_io_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", qpi_io_oe); end
    checks++; if (qpi_io_do !== 4'h0) begin errors++; $display("FAIL reset_do: got %h expected 0", qpi_io_do); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_first !== 1'b0) begin errors++; $display("FAIL reset_rx_first: got %b expected 0", rx_first); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    checks++; if (qpi_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", qpi_err); end
    checks++; if (qpi_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", qpi_rdy); end
    reset = 1'b0;
    wait_cyc(3);
    checks++; if (qpi_rdy !== 1'b1) begin errors++; $display("FAIL rdy_idle: got %b expected 1", qpi_rdy); end
    core_busy = 1'b1;
    wait_cyc(3);
    checks++; if (qpi_rdy !== 1'b0) begin errors++; $display("FAIL rdy_busy: got %b expected 0", qpi_rdy); end
    core_busy = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_write();
    logic [7:0] exp[$];
    int base;
    base = rx_q.size();
    exp.push_back(8'h21);
    for (int i = 1; i <= 12; i++) exp.push_back(8'(i));
    host_begin();
    foreach (exp[i]) host_send(exp[i]);
    host_end();
    checks++; if (rx_q.size() - base !== 13) begin errors++; $display("FAIL write_count: got %0d expected 13", rx_q.size() - base); end
    for (int i = 0; i < 13 && base + i < rx_q.size(); i++) begin
      checks++; if (rx_q[base+i] !== exp[i]) begin errors++; $display("FAIL write_data[%0d]: got %h expected %h", i, rx_q[base+i], exp[i]); end
      checks++; if (rxf_q[base+i] !== (i == 0)) begin errors++; $display("FAIL write_first[%0d]: got %b expected %b", i, rxf_q[base+i], (i == 0)); end
    end
    checks++; if (qpi_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", qpi_err); end
    checks++; if (qpi_rdy !== 1'b1) begin errors++; $display("FAIL write_rdy: got %b expected 1", qpi_rdy); end
  endtask

  task automatic test_random_write();
    for (int t = 0; t < 3; t++) begin
      logic [7:0] exp[$];
      int base, n;
      base = rx_q.size();
      n = $urandom_range(2, 10);
      for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
      host_begin();
      foreach (exp[i]) host_send(exp[i]);
      host_end();
      checks++; if (rx_q.size() - base !== n) begin errors++; $display("FAIL rwrite_count: got %0d expected %0d", rx_q.size() - base, n); end
      for (int i = 0; i < n && base + i < rx_q.size(); i++) begin
        checks++; if (rx_q[base+i] !== exp[i] || rxf_q[base+i] !== (i == 0)) begin
          errors++; $display("FAIL rwrite_data[%0d]: got %h/%b expected %h/%b", i, rx_q[base+i], rxf_q[base+i], exp[i], (i == 0));
        end
      end
    end
  endtask

  task automatic test_read();
    int base, tbase;
    base = rx_q.size();
    host_begin();
    host_send(8'h22);
    core_tx_start();
    for (int i = 0; i < 8; i++) begin slot_valid[i] = 1'b1; slot_data[i] = 8'hA0 + 8'(i); end
    tbase = tx_ready_cnt;
    host_read(8);
    checks++; if (rx_q.size() - base !== 1 || rx_q[base] !== 8'h22 || rxf_q[base] !== 1'b1) begin
      errors++; $display("FAIL read_cmd: got %0d bytes first %h expected 1 byte 22", rx_q.size() - base, rx_q[base]);
    end
    checks++; if (oe_at_dummy !== 1'b0) begin errors++; $display("FAIL read_dummy_oe: got %b expected 0", oe_at_dummy); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL read_data[%0d]: got %h expected %h", i, got[i], 8'hA0 + 8'(i)); end
    end
    checks++; if (tx_ready_cnt - tbase !== 8) begin errors++; $display("FAIL read_tx_ready: got %0d expected 8", tx_ready_cnt - tbase); end
    checks++; if (qpi_io_oe !== 1'b0) begin errors++; $display("FAIL read_end_oe: got %b expected 0", qpi_io_oe); end
    checks++; if (qpi_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", qpi_err); end
  endtask

  task automatic test_random_read();
    for (int t = 0; t < 3; t++) begin
      logic [7:0] exp[16];
      int n, exp_ready, tbase;
      n = $urandom_range(1, 8);
      exp_ready = 0;
      for (int i = 0; i < n; i++) begin
        slot_valid[i] = 1'($urandom_range(0, 1));
        slot_data[i]  = 8'($urandom);
        exp[i] = slot_valid[i] ? slot_data[i] : 8'hFF;
        if (slot_valid[i]) exp_ready++;
      end
      host_begin();
      host_send(8'h22);
      core_tx_start();
      tbase = tx_ready_cnt;
      host_read(n);
      for (int i = 0; i < n; i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rread_data[%0d]: got %h expected %h", i, got[i], exp[i]); end
      end
      checks++; if (tx_ready_cnt - tbase !== exp_ready) begin errors++; $display("FAIL rread_tx_ready: got %0d expected %0d", tx_ready_cnt - tbase, exp_ready); end
    end
  endtask

  task automatic test_poll();
    logic [7:0] exp[4];
    int tbase;
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    host_begin();
    host_send(8'h23); host_send(8'h01); host_send(8'h10); host_send(8'h03);
    core_tx_start();
    for (int i = 0; i < 4; i++) begin slot_valid[i] = (i == 3); slot_data[i] = 8'h00; end
    tbase = tx_ready_cnt;
    host_read(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL poll_data[%0d]: got %h expected %h", i, got[i], exp[i]); end
    end
    checks++; if (tx_ready_cnt - tbase !== 1) begin errors++; $display("FAIL poll_tx_ready: got %0d expected 1", tx_ready_cnt - tbase); end
  endtask

  task automatic test_abort();
    int base;
    base = rx_q.size();
    host_begin();
    host_send(8'hAB);
    host_io  = 4'hC;
    host_clk = 1'b0;
    wait_cyc(H);
    host_csb = 1'b1;
    wait_cyc(H);
    host_clk = 1'b1;
    wait_cyc(H);
    checks++; if (rx_q.size() - base !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", rx_q.size() - base); end
    checks++; if (qpi_err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b expected 1", qpi_err); end
    checks++; if (qpi_rdy !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", qpi_rdy); end
    checks++; if (qpi_io_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", qpi_io_oe); end
    base = rx_q.size();
    host_begin();
    checks++; if (qpi_err !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b expected 0", qpi_err); end
    host_send(8'h5A);
    host_end();
    checks++; if (rx_q.size() - base !== 1 || rx_q[base] !== 8'h5A || rxf_q[base] !== 1'b1) begin
      errors++; $display("FAIL abort_next: got %0d bytes first %h expected 1 byte 5A", rx_q.size() - base, rx_q[base]);
    end
  endtask

  task automatic test_misuse();
    logic [7:0] exp[3];
    int base;
    exp = '{8'h24, 8'h96, 8'h3C};
    base = rx_q.size();
    host_begin();
    host_send(exp[0]);
    host_io  = exp[1][7:4];
    host_clk = 1'b0;
    wait_cyc(H);
    core_tx_start();
    host_io  = exp[1][3:0];
    host_clk = 1'b1;
    wait_cyc(H);
    host_send(exp[2]);
    host_end();
    checks++; if (qpi_err !== 1'b1) begin errors++; $display("FAIL misuse_err: got %b expected 1", qpi_err); end
    checks++; if (rx_q.size() - base !== 3) begin errors++; $display("FAIL misuse_count: got %0d expected 3", rx_q.size() - base); end
    for (int i = 0; i < 3 && base + i < rx_q.size(); i++) begin
      checks++; if (rx_q[base+i] !== exp[i]) begin errors++; $display("FAIL misuse_data[%0d]: got %h expected %h", i, rx_q[base+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_tx();
    int base;
    host_begin();
    host_send(8'h22);
    core_tx_start();
    host_clk = 1'b0;
    wait_cyc(H);
    tx_valid = 1'b1;
    tx_data  = 8'hE7;
    host_clk = 1'b1;
    wait_cyc(H);
    checks++; if (qpi_io_oe !== 1'b1 || qpi_io_do !== 4'hE) begin errors++; $display("FAIL midtx_drive: got oe %b do %h expected oe 1 do e", qpi_io_oe, qpi_io_do); end
    reset = 1'b1;
    #1;
    checks++; if (qpi_io_oe !== 1'b0) begin errors++; $display("FAIL midtx_oe_release: got %b expected 0", qpi_io_oe); end
    checks++; if (qpi_io_do !== 4'h0 || rx_valid !== 1'b0 || rx_first !== 1'b0 || tx_ready !== 1'b0 || qpi_err !== 1'b0 || qpi_rdy !== 1'b0) begin
      errors++; $display("FAIL midtx_reset_vals: got do %h rxv %b rxf %b txr %b err %b rdy %b expected all 0", qpi_io_do, rx_valid, rx_first, tx_ready, qpi_err, qpi_rdy);
    end
    tx_valid = 1'b0;
    host_csb = 1'b1;
    host_clk = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4);
    base = rx_q.size();
    host_begin();
    host_send(8'h21);
    host_send(8'h05);
    host_end();
    checks++; if (rx_q.size() - base !== 2) begin errors++; $display("FAIL midtx_next_count: got %0d expected 2", rx_q.size() - base); end
    checks++; if (rx_q.size() - base == 2 && (rx_q[base] !== 8'h21 || rx_q[base+1] !== 8'h05 || rxf_q[base] !== 1'b1 || rxf_q[base+1] !== 1'b0)) begin
      errors++; $display("FAIL midtx_next_data: got %h %h expected 21 05", rx_q[base], rx_q[base+1]);
    end
    checks++; if (qpi_err !== 1'b0) begin errors++; $display("FAIL midtx_next_err: got %b expected 0", qpi_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_write();
    test_read();
    test_random_read();
    test_poll();
    test_abort();
    test_misuse();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
